// File: rtl/nx_fifo_rd_adapter.sv
// Read-side drain for nx_fifo: pops into a 2-entry head/skid buffer and
// presents a registered valid/ready stream, with flush and a beat counter.
module nx_fifo_rd_adapter #(
  parameter int WIDTH      = 71,
  parameter bit DATA_RESET = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             fifo_clear,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic             valid_q;
  logic             clear_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             pop;
  logic             cnt_max;

  assign accept  = valid_q && out_ready;
  assign cnt_max = &cnt_q;

  // Pop depends only on registered state and the FIFO flag, never on
  // out_ready; clear_q blocks a pop racing the FIFO's own clear.
  assign pop = !rst && !flush && !clear_q &&
               !fifo_empty && (occ_q != OCC2);

  assign fifo_ren   = pop;
  assign fifo_clear = clear_q;
  assign out_valid  = valid_q;
  assign out_data   = slot0_q;
  assign occupancy  = occ_q;
  assign beat_cnt   = cnt_q;

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (occ_q)
      OCC0: begin
        if (pop) begin
          slot0_d = fifo_rdata;
          occ_d   = OCC1;
        end
      end
      OCC1: begin
        if (pop && accept) begin
          slot0_d = fifo_rdata;
        end else if (pop) begin
          slot1_d = fifo_rdata;
          occ_d   = OCC2;
        end else if (accept) begin
          occ_d = OCC0;
        end
      end
      OCC2: begin
        if (accept) begin
          slot0_d = slot1_q;
          occ_d   = OCC1;
        end
      end
      default: occ_d = OCC0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= OCC0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
    end else if (flush) begin
      occ_q   <= OCC0;
      valid_q <= 1'b0;
      clear_q <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      valid_q <= (occ_d != OCC0);
      clear_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if (DATA_RESET) begin
        slot0_q <= '0;
        slot1_q <= '0;
      end
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // Accepts during flush still count; the dropped data does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && !cnt_max) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_nx_fifo_rd_adapter.sv
// Directed bench for nx_fifo_rd_adapter with a simple FIFO model.
// A second 4-bit-counter instance covers counter saturation.
module tb_nx_fifo_rd_adapter;

  localparam int W = 71;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         out_ready;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         fifo_ren;
  logic         fifo_clear;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [31:0]  beat_cnt;

  logic         rst2;
  logic         ready2;
  logic         ren2;
  logic         clear2;
  logic         valid2;
  logic [W-1:0] data2;
  logic [1:0]   occ2;
  logic [3:0]   cnt2;

  logic [W-1:0] mem [0:2047];
  int wp = 0;
  int rp = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  assign fifo_rdata = mem[rp[10:0]];

  always @(posedge clk) begin
    if (fifo_clear) rp <= wp;
    else if (fifo_ren) rp <= rp + 1;
  end

  nx_fifo_rd_adapter #(.WIDTH(W), .DATA_RESET(1'b1), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .fifo_clear (fifo_clear),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .beat_cnt   (beat_cnt)
  );

  nx_fifo_rd_adapter #(.WIDTH(W), .DATA_RESET(1'b1), .CNT_W(4)) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .fifo_empty (1'b0),
    .fifo_rdata (71'h3C),
    .fifo_ren   (ren2),
    .fifo_clear (clear2),
    .flush      (1'b0),
    .out_valid  (valid2),
    .out_ready  (ready2),
    .out_data   (data2),
    .occupancy  (occ2),
    .beat_cnt   (cnt2)
  );

  task automatic push(input logic [W-1:0] v);
    mem[wp[10:0]] = v;
    wp = wp + 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_ren !== 1'b0 || out_valid !== 1'b0 ||
          occupancy !== 2'd0 || beat_cnt !== 32'd0) begin
        errors++;
        $display("FAIL idle: ren=%b valid=%b occ=%0d cnt=%0d want 0 0 0 0",
                 fifo_ren, out_valid, occupancy, beat_cnt);
      end
    end
  endtask

  task automatic test_streaming;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%0h want 1 %0h",
                 i, out_valid, out_data, i);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 32'd8) begin
      errors++;
      $display("FAIL stream_end: valid=%b cnt=%0d want 0 8",
               out_valid, beat_cnt);
    end
  endtask

  task automatic test_backpressure;
    int rp0;
    @(negedge clk);
    out_ready = 1'b0;
    rp0 = rp;
    for (int i = 0; i < 4; i++) push(W'(8'hA + i));
    repeat (3) @(negedge clk);
    checks++;
    if (rp - rp0 !== 2 || occupancy !== 2'd2 ||
        fifo_ren !== 1'b0 || out_data !== W'(8'hA)) begin
      errors++;
      $display("FAIL bp_hold: pops=%0d occ=%0d ren=%b data=%0h want 2 2 0 a",
               rp - rp0, occupancy, fifo_ren, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_data !== W'(8'hA) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: data=%0h want a", out_data);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(8'hA + i)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%b data=%0h want 1 %0h",
                 i, out_valid, out_data, 8'hA + i);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 32'd12) begin
      errors++;
      $display("FAIL bp_end: valid=%b cnt=%0d want 0 12",
               out_valid, beat_cnt);
    end
  endtask

  task automatic test_random;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (fifo_ren && (fifo_empty || occupancy == 2'd2)) begin
        errors++;
        $display("FAIL rnd_ren: ren=1 empty=%b occ=%0d want ren=0",
                 fifo_empty, occupancy);
      end
      if (sent < 1000 && $urandom_range(0, 1) == 1) begin
        push(W'(32'h1000 + sent));
        sent++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== W'(32'h1000 + got)) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got %0h want %0h",
                   got, out_data, 32'h1000 + got);
        end
        got++;
      end
    end
    if (got < 1000) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout: got %0d beats want 1000", got);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1 ||
        beat_cnt !== 32'd1012) begin
      errors++;
      $display("FAIL rnd_end: valid=%b empty=%b cnt=%0d want 0 1 1012",
               out_valid, fifo_empty, beat_cnt);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(W'(8'h21 + i));
    repeat (3) @(negedge clk);
    checks++;
    if (occupancy !== 2'd2 || wp - rp !== 3) begin
      errors++;
      $display("FAIL fl_pre: occ=%0d left=%0d want 2 3",
               occupancy, wp - rp);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL fl_ren: ren=%b want 0", fifo_ren);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_clear !== 1'b1 ||
        out_data !== '0 || occupancy !== 2'd0 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL fl_post: valid=%b clr=%b data=%0h occ=%0d ren=%b want 0 1 0 0 0",
               out_valid, fifo_clear, out_data, occupancy, fifo_ren);
    end
    @(negedge clk);
    checks++;
    if (fifo_clear !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL fl_clr: clr=%b empty=%b want 0 1",
               fifo_clear, fifo_empty);
    end
    push(W'(8'h55));
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(8'h55)) begin
      errors++;
      $display("FAIL fl_next: valid=%b data=%0h want 1 55",
               out_valid, out_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 32'd1013) begin
      errors++;
      $display("FAIL fl_end: valid=%b cnt=%0d want 0 1013",
               out_valid, beat_cnt);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    push(W'(8'h77));
    push(W'(8'h78));
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd1 || out_data !== W'(8'h77)) begin
      errors++;
      $display("FAIL rm_pre: occ=%0d data=%0h want 1 77", occupancy, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL rm_ren: ren=%b want 0", fifo_ren);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || beat_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rm_post: valid=%b occ=%0d cnt=%0d want 0 0 0",
               out_valid, occupancy, beat_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(8'h78)) begin
      errors++;
      $display("FAIL rm_fifo: valid=%b data=%0h want 1 78",
               out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_saturation;
    @(negedge clk);
    rst2 = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (cnt2 !== 4'd14 || valid2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_14: cnt=%0d valid=%b want 14 1", cnt2, valid2);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (cnt2 !== 4'd15 || occ2 !== 2'd1) begin
      errors++;
      $display("FAIL sat_15: cnt=%0d occ=%0d want 15 1", cnt2, occ2);
    end
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checks++;
    if (valid2 !== 1'b0 || cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL sat_rst: valid=%b cnt=%0d want 0 0", valid2, cnt2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst2      = 1'b1;
    ready2    = 1'b1;
    repeat (3) @(posedge clk);
    test_reset;
    test_streaming;
    test_backpressure;
    test_random;
    test_flush;
    test_reset_mid;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nx_fifo_rd_adapter.md
Name: nx_fifo_rd_adapter

Overview:
- Read-side drain for an nx_fifo instance. Pops the FIFO and presents its contents as a registered valid/ready stream.
- `fifo_ren` is derived only from registered local occupancy and `fifo_empty`, so downstream `out_ready` never has a combinational path into the FIFO read pointer.
- Holds a 2-entry local buffer (head plus skid) so steady-state throughput is one beat per cycle.
- Also provides a flush that clears the FIFO and the local buffer together, plus a delivered-beat counter.

Parameters:
- WIDTH, 71, data width in bits; must match the attached FIFO.
- DATA_RESET, 1, 1 = local data registers reset/flush to 0; 0 = data registers are not reset.
- CNT_W, 32, width of the `beat_cnt` counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_rdata  input  WIDTH  FIFO head data; valid whenever `fifo_empty` = 0.
- fifo_ren  output  1  pop strobe to the FIFO; combinational.
- fifo_clear  output  1  clear strobe to the FIFO; registered, 1-cycle pulse.
- flush  input  1  discard all data in the FIFO and the local buffer.
- out_valid  output  1  stream valid; registered.
- out_ready  input  1  stream ready from the consumer.
- out_data  output  WIDTH  stream data; registered (head slot).
- occupancy  output  2  number of local entries, 0..2.
- beat_cnt  output  CNT_W  count of accepted beats (`out_valid` && `out_ready`); saturates at all-ones.

Behaviour:
- Storage: slot0 (head, drives `out_data`) and slot1 (skid). State is `occ` ∈ {0, 1, 2}; `out_valid` = (`occ` != 0), registered.
- Definitions:
  - `accept` = `out_valid` && `out_ready`.
  - `fifo_ren` = !`rst` && !`flush` && !`fifo_empty` && (`occ` != 2). No dependence on `out_ready`.
  - `pop` = `fifo_ren`. Data captured on a pop is `fifo_rdata` in the same cycle.
- Next state when `flush` = 0:
  - occ0, pop: slot0 <= rdata, occ <= 1.
  - occ1, pop && accept: slot0 <= rdata, occ stays 1.
  - occ1, pop && !accept: slot1 <= rdata, occ <= 2.
  - occ1, !pop && accept: occ <= 0.
  - occ2, accept: slot0 <= slot1, occ <= 1. No pop is possible in occ2.
  - Any other case: hold all state.
- Ordering: strict FIFO order; no beat is lost or duplicated.
- Stability: while `out_valid` && !`out_ready`, `out_data` is held stable.
- Latency: the first beat appears on `out_valid` one cycle after `fifo_empty` falls, provided `occ` = 0.
- Throughput: with `out_ready` held at 1, `occ` stays at 1 and one beat transfers per cycle.
- Backpressure: with `out_ready` = 0, at most two pops occur, then `fifo_ren` stays 0 until an `accept`.
- Flush (highest priority below `rst`):
  - In the flush cycle: `fifo_ren` = 0, `occ` <= 0.
  - If DATA_RESET = 1: slot0 and slot1 <= 0.
  - `fifo_clear` <= 1 for exactly the next cycle; it stays high only if `flush` is still asserted.
  - An `accept` coinciding with `flush` still counts in `beat_cnt`; its data is then dropped.
- Post-flush: `fifo_ren` may reassert the cycle after `flush` deasserts. The FIFO clear completes in the same edge where `fifo_clear` is high, so any stale pop reads the FIFO's zero/empty data. To prevent this, `fifo_ren` is also gated by `fifo_clear`.
- Reset (`rst` = 1 at posedge):
  - `occ` = 0, `out_valid` = 0, `fifo_clear` = 0, `beat_cnt` = 0.
  - slot0/slot1 = 0 if DATA_RESET = 1.
  - `fifo_ren` = 0 while `rst` is high.
  - Reset mid-transfer discards local entries; the FIFO is not cleared by this block.
- `beat_cnt`: increments by 1 per `accept`; holds at 2^CNT_W − 1.
- `fifo_empty` = 1 with `occ` = 0: `out_valid` stays 0 and no pop is issued, so the FIFO never sees an underflow from this block.

Test Plan:
- Post-reset idle: `rst` 1→0, `fifo_empty` = 1 for 10 cycles → `fifo_ren` = 0, `out_valid` = 0, `occupancy` = 0, `beat_cnt` = 0.
- Streaming: push 8 words 0x1..0x8, `out_ready` = 1 → `out_valid` rises 1 cycle after `fifo_empty` falls; data 0x1..0x8 on 8 consecutive cycles; `beat_cnt` = 8.
- Backpressure: 4 words 0xA..0xD, `out_ready` = 0 → exactly 2 pops, `occupancy` = 2, `fifo_ren` = 0, `out_data` = 0xA held. Release `out_ready` → 0xA, 0xB, 0xC, 0xD in order with no gaps after the first.
- Random `out_ready` (50%) over 1000 words → scoreboard order exact, no drops or duplicates, `fifo_ren` never high when `fifo_empty` = 1 or `occupancy` = 2.
- Flush at `occupancy` = 2 with 3 words left in the FIFO → next cycle `out_valid` = 0, `fifo_clear` = 1 for 1 cycle, slots = 0. A subsequent push 0x55 emerges as the next beat.
- Saturation: CNT_W = 4, 20 accepts → `beat_cnt` = 15. Reset asserted with `occupancy` = 1 → next cycle `out_valid` = 0, `beat_cnt` = 0.
